// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Optional byte-lane stores are enabled by defining DMEM_BYTE_WRITE_EN.
package dmem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int LAT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // A word access is legal only when aligned and inside the stored word range.
    function automatic logic addr_error(input logic [31:0] addr, input int aw);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the memory stage and the data-memory responder.
// req_be exists only when DMEM_BYTE_WRITE_EN is defined.
interface dmem_if;

    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0]  req_be;
`endif
    logic        req_ready;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
`ifdef DMEM_BYTE_WRITE_EN
        output req_be,
`endif
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, busy, resp_valid, resp_rdata, resp_err
    );

    modport slave (
`ifdef DMEM_BYTE_WRITE_EN
        input  req_be,
`endif
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, busy, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_ram.sv
// Single-port synchronous word RAM with per-byte write enables and registered read.
// Contents are never reset so the array maps onto block RAM.
module dmem_ram #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Read-first: a store returns the old word, which the responder discards.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MIPS memory stage: valid/ready request, fixed latency, one-cycle response.
// Define DMEM_BYTE_WRITE_EN to honour req_be on stores; otherwise stores write the full word.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic clk,
    input  logic reset,
    dmem_if.slave bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [LAT_W-1:0] CNT_INIT = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

    dmem_state_t       state_reg, state_next;
    logic [LAT_W-1:0]  cnt_reg;
    logic              write_reg;
    logic [31:0]       addr_reg;
    logic [31:0]       wdata_reg;
    logic              err_reg;
    logic              accept;

    logic              cur_write;
    logic [31:0]       cur_addr;
    logic [31:0]       cur_wdata;
    logic [3:0]        cur_be;
    logic              cur_err;

    logic              ram_en;
    logic              ram_we;
    logic [31:0]       ram_rdata;

    logic              ready_c, busy_c, valid_c, err_c;
    logic [31:0]       rdata_c;

    assign accept = (state_reg == IDLE) && bus.req_valid;

    // With zero latency the RAM edge is the acceptance edge, so the live request must reach the RAM.
    assign cur_write = (state_reg == IDLE) ? bus.req_write : write_reg;
    assign cur_addr  = (state_reg == IDLE) ? bus.req_addr  : addr_reg;
    assign cur_wdata = (state_reg == IDLE) ? bus.req_wdata : wdata_reg;
    assign cur_err   = addr_error(cur_addr, AW);

`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0] be_reg;
    assign cur_be = (state_reg == IDLE) ? bus.req_be : be_reg;
`else
    assign cur_be = 4'b1111;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg   <= '0;
            write_reg <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
`ifdef DMEM_BYTE_WRITE_EN
            be_reg    <= '0;
`endif
        end else if (accept) begin
            cnt_reg   <= CNT_INIT;
            write_reg <= bus.req_write;
            addr_reg  <= bus.req_addr;
            wdata_reg <= bus.req_wdata;
            err_reg   <= addr_error(bus.req_addr, AW);
`ifdef DMEM_BYTE_WRITE_EN
            be_reg    <= bus.req_be;
`endif
        end else if ((state_reg == WAIT) && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    // Gated by reset so an aborted access can never touch the array while reset is held.
    assign ram_en = (state_next == RESP) && reset;
    assign ram_we = cur_write && !cur_err;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .idx   (cur_addr[AW+1:2]),
        .wdata (cur_wdata),
        .be    (cur_be),
        .rdata (ram_rdata)
    );

    always_comb begin
        ready_c = (state_reg == IDLE);
        busy_c  = (state_reg != IDLE);
        valid_c = (state_reg == RESP);
        err_c   = (state_reg == RESP) && err_reg;
        rdata_c = '0;
        if ((state_reg == RESP) && !err_reg && !write_reg) begin
            rdata_c = ram_rdata;
        end
    end

    assign bus.req_ready  = ready_c;
    assign bus.busy       = busy_c;
    assign bus.resp_valid = valid_c;
    assign bus.resp_rdata = rdata_c;
    assign bus.resp_err   = err_c;

endmodule
